uart_tx_fifo_drain: RTL and testbench
=====================================

Name: uart_tx_fifo_drain

Overview:
- UART transmit engine that sits on the read side of the TX FIFO. It pops bytes through the FIFO's rd_en/rd_data/empty interface and serialises each one as a standard asynchronous frame: start bit, data LSB-first, optional parity, stop bit(s).
- An internal baud counter sets bit timing; no external tick is needed.
- Pairs with the FIFO write side fed by the host/bus logic.

Parameters:
- W_DATA, 8: data bits per frame; must equal the FIFO width.
- CLKS_PER_BIT, 868: clk cycles per UART bit (100 MHz / 115200). Must be >= 2.
- STOP_BITS, 1: number of stop bits; legal values are 1 or 2.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- tx_en  input  1  permits new frames to start. Dropping it never truncates a frame already in progress.
- par_odd  input  1  parity sense, 1 = odd, 0 = even. Used only with the optional feature.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_data  input  W_DATA  FIFO read data, valid the cycle after an accepted fifo_rd_en.
- fifo_rd_en  output  1  single-cycle FIFO pop request.
- tx  output  1  serial line, registered, idles high.
- busy  output  1  high while a frame is being fetched or sent.
- frame_done  output  1  one-cycle pulse on the last clk of the final stop bit.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: tx=1, busy=0, fifo_rd_en=0, frame_done=0, state=IDLE, baud counter=0, bit index=0.
- States: IDLE, READ, LOAD, START, DATA, PARITY (present only with the macro), STOP.
- IDLE:
  - tx=1, busy=0.
  - If tx_en && !fifo_empty, go to READ; otherwise stay.
- READ:
  - Lasts 1 cycle; fifo_rd_en=1 (Moore output, the only state that asserts it); busy=1.
  - Always goes to LOAD.
- LOAD:
  - Lasts 1 cycle; fifo_rd_data is captured into the shift register at the end of this cycle.
  - Goes to START.
- Start-of-frame latency: tx falls on the 3rd rising edge after the IDLE cycle that saw the start condition.
- Bit timing:
  - The baud counter runs 0..CLKS_PER_BIT-1 and is cleared on every state entry.
  - Each bit (start, data, parity, stop) holds tx for exactly CLKS_PER_BIT cycles.
  - Counter width is $clog2(CLKS_PER_BIT).
- START: tx=0 for one bit time, then go to DATA with bit index 0.
- DATA:
  - tx = shift[0]; shift right at the end of each bit.
  - After bit W_DATA-1, go to PARITY if enabled, else STOP.
- STOP:
  - tx=1 for STOP_BITS bit times.
  - frame_done pulses on the last cycle, then go to IDLE.
- Back-to-back frames: with the FIFO non-empty and tx_en held, exactly 3 extra idle-high cycles (IDLE, READ, LOAD) separate the end of the stop bit(s) from the next start bit.
- FIFO and tx_en rules:
  - fifo_rd_en is never asserted while fifo_empty=1 was sampled in IDLE.
  - fifo_empty changes after READ are ignored.
  - tx_en deasserted mid-frame: the frame completes, and the next frame is not started.
- Reset mid-frame: at the next edge tx=1 and state=IDLE. The popped byte is discarded and no frame_done is generated.
- tx is driven only from registered state, so it never glitches.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - The PARITY state is inserted after DATA, lasting one bit time.
  - tx = (^data) ^ par_odd, giving even parity when par_odd=0 and odd parity when par_odd=1.
  - Frame length is 1+W_DATA+1+STOP_BITS bits.
- Undefined:
  - No PARITY state; par_odd is ignored.
  - Frame length is 1+W_DATA+STOP_BITS bits.

Test Plan:
- Single byte (CLKS_PER_BIT=4, STOP_BITS=1, no macro): FIFO holds 0xA5, tx_en=1 -> fifo_rd_en high for exactly 1 cycle. Then tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. frame_done pulses once at cycle 40 of the frame; busy drops after it.
- Back-to-back: FIFO holds 0x00, 0xFF -> two frames with exactly 3 idle-high clk between the stop bit of the first and the start bit of the second. Exactly 2 fifo_rd_en pulses.
- Parity (macro defined, 0xA5, four ones): par_odd=0 -> parity bit 0. par_odd=1 -> parity bit 1. 11-bit frame, 44 cycles.
- Flow control: fifo_empty=1 for 100 cycles -> tx stays 1, fifo_rd_en stays 0. tx_en dropped in the middle of the data bits -> current frame finishes and no further pop occurs.
- Reset mid-frame: assert rst for 1 cycle during data bit 3 -> tx=1 and busy=0 at the next edge, no frame_done. The next frame starts cleanly from IDLE.
- STOP_BITS=2: byte 0x3C -> stop segment is 8 cycles high before frame_done.

Source files
------------

// File: rtl/uart_tx_fifo_drain_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_drain_if
// Read-side FIFO handshake between the UART transmit engine and the TX FIFO.
//
// Signals:
//   fifo_empty    FIFO empty flag            (FIFO -> engine)
//   fifo_rd_data  read data, valid the cycle after an accepted pop (FIFO -> engine)
//   fifo_rd_en    single-cycle pop request   (engine -> FIFO)
//
// Modports:
//   master  the transmit engine, which issues pops
//   slave   the FIFO, which answers them
// -----------------------------------------------------------------------------
interface uart_tx_fifo_drain_if #(
   parameter int W_DATA = 8
);
   logic              fifo_empty;
   logic [W_DATA-1:0] fifo_rd_data;
   logic              fifo_rd_en;

   modport master (
      input  fifo_empty,
      input  fifo_rd_data,
      output fifo_rd_en
   );

   modport slave (
      output fifo_empty,
      output fifo_rd_data,
      input  fifo_rd_en
   );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_drain
// UART transmit engine on the read side of the TX FIFO. It pops one byte at a
// time and sends it as: start bit, W_DATA data bits LSB-first, optional parity
// bit, STOP_BITS stop bits. Bit timing comes from an internal baud counter.
//
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after the
// data bits (even parity when par_odd_i=0, odd when par_odd_i=1). Without it
// par_odd_i is ignored.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   tx_en_i       permits new frames to start; never truncates a running frame
//   par_odd_i     parity sense (only used with UART_TX_PARITY_EN)
//   fifo          FIFO read handshake (master side)
//   tx_o          registered serial line, idles high
//   busy_o        high while a frame is being fetched or sent
//   frame_done_o  one-cycle pulse on the last clk of the final stop bit
// -----------------------------------------------------------------------------
module uart_tx_fifo_drain #(
   parameter int W_DATA       = 8,
   parameter int CLKS_PER_BIT = 868,
   parameter int STOP_BITS    = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        tx_en_i,
   input  logic                        par_odd_i,
   uart_tx_fifo_drain_if.master        fifo,
   output logic                        tx_o,
   output logic                        busy_o,
   output logic                        frame_done_o
);

   localparam int W_CNT = $clog2(CLKS_PER_BIT);
   // One index register serves both the data bits and the stop bits.
   localparam int W_IDX = (W_DATA > 2) ? $clog2(W_DATA) : 1;

   localparam logic [W_CNT-1:0] CNT_LAST  = W_CNT'(CLKS_PER_BIT - 1);
   localparam logic [W_IDX-1:0] DATA_LAST = W_IDX'(W_DATA - 1);
   localparam logic [W_IDX-1:0] STOP_LAST = W_IDX'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
   } state_e;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_LOAD, S_START, S_DATA, S_STOP
   } state_e;
`endif

   state_e            state_q, state_d;
   logic [W_CNT-1:0]  cnt_q, cnt_d;
   logic [W_IDX-1:0]  bit_q, bit_d;
   logic [W_DATA-1:0] shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              rd_en_q, rd_en_d;
   logic              done_q, done_d;
   logic              bit_end;
`ifdef UART_TX_PARITY_EN
   logic              par_q, par_d;
`endif

   assign bit_end = (cnt_q == CNT_LAST);

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q + W_CNT'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (tx_en_i && !fifo.fifo_empty) state_d = S_READ;
         end
         S_READ: begin
            cnt_d   = '0;
            state_d = S_LOAD;
         end
         S_LOAD: begin
            // Read data is valid now, one cycle after the pop.
            cnt_d   = '0;
            bit_d   = '0;
            shift_d = fifo.fifo_rd_data;
`ifdef UART_TX_PARITY_EN
            par_d   = ^fifo.fifo_rd_data;
`endif
            state_d = S_START;
         end
         S_START: begin
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_d   = '0;
               shift_d = shift_q >> 1;
               if (bit_q == DATA_LAST) begin
                  bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + W_IDX'(1);
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               if (bit_q == STOP_LAST) begin
                  bit_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  bit_d = bit_q + W_IDX'(1);
               end
            end
         end
         default: begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = S_IDLE;
         end
      endcase

      // Outputs are decoded from the next state and registered alongside it,
      // so they line up exactly with the state and never glitch.
      tx_d = 1'b1;
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_d = par_d ^ par_odd_i;
`endif
         default:  tx_d = 1'b1;
      endcase
      busy_d  = (state_d != S_IDLE);
      rd_en_d = (state_d == S_READ);
      done_d  = (state_d == S_STOP) && (cnt_d == CNT_LAST) && (bit_d == STOP_LAST);
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         rd_en_q <= 1'b0;
         done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         rd_en_q <= rd_en_d;
         done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign fifo.fifo_rd_en = rd_en_q;
   assign tx_o            = tx_q;
   assign busy_o          = busy_q;
   assign frame_done_o    = done_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo_drain
// Directed bench for uart_tx_fifo_drain with CLKS_PER_BIT=4. Instance u_dut0
// uses one stop bit and is fed by a small FIFO model; u_dut1 uses two stop bits
// and is fed a constant 0x3C. Each cycle's outputs are logged on the falling
// edge and the scenario tasks compare the logs against hand-built frames.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo_drain;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int NB0  = 1 + 8 + PB + 1;   // bits per frame, one stop bit
   localparam int NB1  = 1 + 8 + PB + 2;   // bits per frame, two stop bits
   localparam int F0   = NB0 * CPB;        // clk per frame
   localparam int F1   = NB1 * CPB;
   localparam int LOGN = 256;

   logic clk = 1'b0;
   logic rst, tx_en, par_odd, empty1;
   logic tx0, busy0, done0, tx1, busy1, done1;

   int n_run  = 0;
   int n_fail = 0;

   uart_tx_fifo_drain_if #(.W_DATA(8)) if0 ();
   uart_tx_fifo_drain_if #(.W_DATA(8)) if1 ();

   uart_tx_fifo_drain #(.W_DATA(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut0 (
      .clk          (clk),
      .rst          (rst),
      .tx_en_i      (tx_en),
      .par_odd_i    (par_odd),
      .fifo         (if0.master),
      .tx_o         (tx0),
      .busy_o       (busy0),
      .frame_done_o (done0)
   );

   uart_tx_fifo_drain #(.W_DATA(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut1 (
      .clk          (clk),
      .rst          (rst),
      .tx_en_i      (tx_en),
      .par_odd_i    (par_odd),
      .fifo         (if1.master),
      .tx_o         (tx1),
      .busy_o       (busy1),
      .frame_done_o (done1)
   );

   always #5 clk = ~clk;

   // FIFO model for u_dut0; a reset flushes whatever is left.
   logic [7:0] mem [16];
   logic [3:0] wr_ptr, rd_ptr;
   assign if0.fifo_empty = (wr_ptr == rd_ptr);
   always @(posedge clk) begin
      if (rst) rd_ptr <= wr_ptr;
      else if (if0.fifo_rd_en && (wr_ptr != rd_ptr)) begin
         if0.fifo_rd_data <= mem[rd_ptr];
         rd_ptr           <= rd_ptr + 4'd1;
      end
   end

   assign if1.fifo_empty   = empty1;
   assign if1.fifo_rd_data = 8'h3C;

   // Per-cycle logs
   logic tx_l [LOGN];
   logic rd_l [LOGN];
   logic fd_l [LOGN];
   logic bz_l [LOGN];
   logic tx1_l[LOGN];
   logic rd1_l[LOGN];
   logic fd1_l[LOGN];

   task automatic push(input logic [7:0] d);
      mem[wr_ptr] = d;
      wr_ptr      = wr_ptr + 4'd1;
   endtask

   // Log n cycles. tx_en drops at sample drop_at; rst is high for one cycle
   // starting at sample rst_at (-1 disables either).
   task automatic record(input int n, input int drop_at, input int rst_at);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (i == drop_at) tx_en = 1'b0;
         if (i == rst_at) rst = 1'b1;
         else if (rst_at >= 0 && i == rst_at + 1) rst = 1'b0;
         tx_l[i]  = tx0;
         rd_l[i]  = if0.fifo_rd_en;
         fd_l[i]  = done0;
         bz_l[i]  = busy0;
         tx1_l[i] = tx1;
         rd1_l[i] = if1.fifo_rd_en;
         fd1_l[i] = done1;
         if (if1.fifo_rd_en) empty1 = 1'b1;
      end
   endtask

   function automatic int count(input int sel, input int lo, input int hi);
      int c = 0;
      for (int i = lo; i < hi; i++) begin
         case (sel)
            0: c += int'(rd_l[i]);
            1: c += int'(fd_l[i]);
            2: c += int'(rd1_l[i]);
            3: c += int'(fd1_l[i]);
            4: c += int'(tx_l[i] !== 1'b1);
            default: c += 0;
         endcase
      end
      return c;
   endfunction

   // Expected level of frame bit k: start, data LSB-first, parity, stop(s).
   function automatic logic exp_bit(input logic [7:0] d, input int k, input logic po);
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
      if (PB == 1 && k == 9) return (^d) ^ po;
      return 1'b1;
   endfunction

   task automatic test_reset();
      rst = 1'b1; tx_en = 1'b0; par_odd = 1'b0; empty1 = 1'b1; wr_ptr = '0;
      @(negedge clk); @(negedge clk);
      n_run++; if (tx0 !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx0); end
      n_run++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy0); end
      n_run++; if (if0.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", if0.fifo_rd_en); end
      n_run++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done0); end
      n_run++; if (tx1 !== 1'b1 || busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_dut1: tx=%b busy=%b want 1/0", tx1, busy1); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      logic [3:0] obs;
      logic       e;
      tx_en = 1'b1;
      push(8'hA5);
      record(F0 + 6, -1, -1);
      n_run++; if (count(0, 0, F0 + 6) !== 1 || rd_l[0] !== 1'b1) begin
         n_fail++; $display("FAIL single_pop: pops=%0d first=%b want 1/1", count(0, 0, F0 + 6), rd_l[0]);
      end
      for (int k = 0; k < NB0; k++) begin
         e   = exp_bit(8'hA5, k, par_odd);
         obs = {tx_l[2+CPB*k+3], tx_l[2+CPB*k+2], tx_l[2+CPB*k+1], tx_l[2+CPB*k]};
         n_run++; if (obs !== {4{e}}) begin n_fail++; $display("FAIL single_bit%0d: got %b want %b", k, obs, {4{e}}); end
      end
      n_run++; if (count(1, 0, F0 + 6) !== 1 || fd_l[F0+1] !== 1'b1) begin
         n_fail++; $display("FAIL single_done: pulses=%0d at_end=%b want 1/1", count(1, 0, F0 + 6), fd_l[F0+1]);
      end
      n_run++; if (bz_l[1] !== 1'b1 || bz_l[F0+2] !== 1'b0) begin
         n_fail++; $display("FAIL single_busy: load=%b after=%b want 1/0", bz_l[1], bz_l[F0+2]);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] obs;
      logic       e;
      logic [2:0] gap;
      tx_en = 1'b1;
      push(8'h00);
      push(8'hFF);
      record(2 * F0 + 10, -1, -1);
      n_run++; if (count(0, 0, 2 * F0 + 10) !== 2) begin n_fail++; $display("FAIL b2b_pops: got %0d want 2", count(0, 0, 2 * F0 + 10)); end
      for (int k = 0; k < NB0; k++) begin
         e   = exp_bit(8'h00, k, par_odd);
         obs = {tx_l[2+CPB*k+3], tx_l[2+CPB*k+2], tx_l[2+CPB*k+1], tx_l[2+CPB*k]};
         n_run++; if (obs !== {4{e}}) begin n_fail++; $display("FAIL b2b_f1_bit%0d: got %b want %b", k, obs, {4{e}}); end
         e   = exp_bit(8'hFF, k, par_odd);
         obs = {tx_l[F0+5+CPB*k+3], tx_l[F0+5+CPB*k+2], tx_l[F0+5+CPB*k+1], tx_l[F0+5+CPB*k]};
         n_run++; if (obs !== {4{e}}) begin n_fail++; $display("FAIL b2b_f2_bit%0d: got %b want %b", k, obs, {4{e}}); end
      end
      gap = {tx_l[F0+4], tx_l[F0+3], tx_l[F0+2]};
      n_run++; if (gap !== 3'b111 || tx_l[F0+5] !== 1'b0) begin
         n_fail++; $display("FAIL b2b_gap: gap=%b start=%b want 111/0", gap, tx_l[F0+5]);
      end
      n_run++; if (rd_l[F0+3] !== 1'b1 || bz_l[F0+2] !== 1'b0) begin
         n_fail++; $display("FAIL b2b_idle: rd=%b busy=%b want 1/0", rd_l[F0+3], bz_l[F0+2]);
      end
      n_run++; if (count(1, 0, 2 * F0 + 10) !== 2) begin n_fail++; $display("FAIL b2b_done: got %0d want 2", count(1, 0, 2 * F0 + 10)); end
   endtask

   task automatic test_parity();
`ifdef UART_TX_PARITY_EN
      logic [3:0] obs;
      tx_en = 1'b1;
      for (int p = 0; p < 2; p++) begin
         par_odd = p[0];
         push(8'hA5);
         record(F0 + 6, -1, -1);
         obs = {tx_l[2+CPB*9+3], tx_l[2+CPB*9+2], tx_l[2+CPB*9+1], tx_l[2+CPB*9]};
         n_run++; if (obs !== {4{p[0]}}) begin n_fail++; $display("FAIL parity_po%0d: got %b want %b", p, obs, {4{p[0]}}); end
         n_run++; if (fd_l[F0+1] !== 1'b1 || count(1, 0, F0 + 6) !== 1) begin
            n_fail++; $display("FAIL parity_len_po%0d: done_at_end=%b pulses=%0d want 1/1", p, fd_l[F0+1], count(1, 0, F0 + 6));
         end
      end
      par_odd = 1'b0;
`endif
   endtask

   task automatic test_flow();
      logic [3:0] obs;
      logic       e;
      tx_en = 1'b1;
      record(100, -1, -1);
      n_run++; if (count(4, 0, 100) !== 0) begin n_fail++; $display("FAIL flow_empty_tx: low cycles=%0d want 0", count(4, 0, 100)); end
      n_run++; if (count(0, 0, 100) !== 0) begin n_fail++; $display("FAIL flow_empty_rd: pops=%0d want 0", count(0, 0, 100)); end
      push(8'h5A);
      push(8'h33);
      record(120, 18, -1);
      for (int k = 0; k < NB0; k++) begin
         e   = exp_bit(8'h5A, k, par_odd);
         obs = {tx_l[2+CPB*k+3], tx_l[2+CPB*k+2], tx_l[2+CPB*k+1], tx_l[2+CPB*k]};
         n_run++; if (obs !== {4{e}}) begin n_fail++; $display("FAIL flow_bit%0d: got %b want %b", k, obs, {4{e}}); end
      end
      n_run++; if (count(0, 0, 120) !== 1) begin n_fail++; $display("FAIL flow_drop_pops: got %0d want 1", count(0, 0, 120)); end
      n_run++; if (count(1, 0, 120) !== 1) begin n_fail++; $display("FAIL flow_drop_done: got %0d want 1", count(1, 0, 120)); end
      n_run++; if (count(4, F0 + 2, 120) !== 0 || bz_l[119] !== 1'b0) begin
         n_fail++; $display("FAIL flow_drop_idle: low cycles=%0d busy=%b want 0/0", count(4, F0 + 2, 120), bz_l[119]);
      end
      // Flush the byte left behind.
      rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [3:0] obs;
      logic       e;
      tx_en = 1'b1;
      push(8'hC3);
      record(40, -1, 19);
      n_run++; if (tx_l[18] !== 1'b0) begin n_fail++; $display("FAIL rstmid_before: tx=%b want 0", tx_l[18]); end
      n_run++; if (tx_l[20] !== 1'b1 || bz_l[20] !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_after: tx=%b busy=%b want 1/0", tx_l[20], bz_l[20]);
      end
      n_run++; if (count(1, 0, 40) !== 0 || count(4, 20, 40) !== 0) begin
         n_fail++; $display("FAIL rstmid_quiet: done=%0d low=%0d want 0/0", count(1, 0, 40), count(4, 20, 40));
      end
      push(8'h81);
      record(F0 + 6, -1, -1);
      for (int k = 0; k < NB0; k++) begin
         e   = exp_bit(8'h81, k, par_odd);
         obs = {tx_l[2+CPB*k+3], tx_l[2+CPB*k+2], tx_l[2+CPB*k+1], tx_l[2+CPB*k]};
         n_run++; if (obs !== {4{e}}) begin n_fail++; $display("FAIL rstmid_next_bit%0d: got %b want %b", k, obs, {4{e}}); end
      end
      n_run++; if (fd_l[F0+1] !== 1'b1 || count(1, 0, F0 + 6) !== 1) begin
         n_fail++; $display("FAIL rstmid_next_done: at_end=%b pulses=%0d want 1/1", fd_l[F0+1], count(1, 0, F0 + 6));
      end
   endtask

   task automatic test_stop2();
      logic [3:0] obs;
      logic [7:0] stop_seg;
      logic       e;
      tx_en  = 1'b1;
      empty1 = 1'b0;
      record(F1 + 6, -1, -1);
      n_run++; if (count(2, 0, F1 + 6) !== 1) begin n_fail++; $display("FAIL stop2_pops: got %0d want 1", count(2, 0, F1 + 6)); end
      for (int k = 0; k < NB1 - 2; k++) begin
         e   = exp_bit(8'h3C, k, par_odd);
         obs = {tx1_l[2+CPB*k+3], tx1_l[2+CPB*k+2], tx1_l[2+CPB*k+1], tx1_l[2+CPB*k]};
         n_run++; if (obs !== {4{e}}) begin n_fail++; $display("FAIL stop2_bit%0d: got %b want %b", k, obs, {4{e}}); end
      end
      for (int i = 0; i < 8; i++) stop_seg[i] = tx1_l[2+CPB*(NB1-2)+i];
      n_run++; if (stop_seg !== 8'hFF) begin n_fail++; $display("FAIL stop2_seg: got %b want 11111111", stop_seg); end
      n_run++; if (fd1_l[F1+1] !== 1'b1 || count(3, 0, F1 + 6) !== 1) begin
         n_fail++; $display("FAIL stop2_done: at_end=%b pulses=%0d want 1/1", fd1_l[F1+1], count(3, 0, F1 + 6));
      end
      n_run++; if (tx1_l[F1+2] !== 1'b1) begin n_fail++; $display("FAIL stop2_idle: tx=%b want 1", tx1_l[F1+2]); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_parity();
      test_flow();
      test_reset_mid();
      test_stop2();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
